// File: rtl/apb_gpio_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_gpio_slave_if
// Brief    : APB3 bus bundle between the bridge (master) and the GPIO completer.
// Revision : 1.0
// ============================================================================
interface apb_gpio_slave_if #(
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [31:0]           PWDATA;
    logic [31:0]           PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface
`default_nettype wire

// File: rtl/apb_gpio_slave.sv
`default_nettype none
// ============================================================================
// Module   : apb_gpio_slave
// Brief    : APB3 GPIO completer, one wait state, with rising-edge interrupts.
// Revision : 1.0
// ============================================================================
module apb_gpio_slave #(
    parameter int GPIO_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  wire                  clk,
    input  wire                  reset,
    apb_gpio_slave_if.slave      apb,
    input  wire [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq
);
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_ACK  = 1'b1;

    localparam logic [2:0] c_W_MODER = 3'd0;
    localparam logic [2:0] c_W_ODR   = 3'd1;
    localparam logic [2:0] c_W_IDR   = 3'd2;
    localparam logic [2:0] c_W_IER   = 3'd3;
    localparam logic [2:0] c_W_ISR   = 3'd4;

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;

    logic [GPIO_WIDTH-1:0] r_moder;
    logic [GPIO_WIDTH-1:0] r_odr;
    logic [GPIO_WIDTH-1:0] r_ier;
    logic [GPIO_WIDTH-1:0] r_isr;
    logic [GPIO_WIDTH-1:0] r_sync1;
    logic [GPIO_WIDTH-1:0] r_idr;
    logic [GPIO_WIDTH-1:0] r_prev;
    logic [31:0]           r_prdata;
    logic                  r_pslverr;

    logic                  w_commit;
    logic [31:0]           w_addr_ext;
    logic [2:0]            w_word;
    logic                  w_err;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic [GPIO_WIDTH-1:0] w_wdata;
    logic [GPIO_WIDTH-1:0] w_w1c;
    logic [GPIO_WIDTH-1:0] w_rise;
    logic [31:0]           w_rdata;
    logic                  w_unused;

    // Decode happens only on the IDLE->ACK edge; ACK always returns to IDLE.
    assign w_commit   = (r_state == c_ST_IDLE) && apb.PSEL && apb.PENABLE;
    assign w_addr_ext = 32'(apb.PADDR);
    assign w_word     = apb.PADDR[4:2];
    assign w_err      = (apb.PADDR[1:0] != 2'b00) || (w_addr_ext > 32'h10) ||
                        (apb.PWRITE && (w_word == c_W_IDR));
    assign w_wr_ok    = w_commit && apb.PWRITE && !w_err;
    assign w_rd_ok    = w_commit && !apb.PWRITE && !w_err;
    assign w_wdata    = apb.PWDATA[GPIO_WIDTH-1:0];
    assign w_w1c      = (w_wr_ok && (w_word == c_W_ISR)) ? w_wdata : '0;
    assign w_rise     = r_idr & ~r_prev & ~r_moder;
    assign w_unused   = ^apb.PWDATA;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (apb.PSEL && apb.PENABLE) w_state_next = c_ST_ACK;
            c_ST_ACK:  w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        apb.PREADY  = (r_state == c_ST_ACK);
        apb.PRDATA  = r_prdata;
        apb.PSLVERR = r_pslverr;
    end

    always_comb begin
        w_rdata = '0;
        case (w_word)
            c_W_MODER: w_rdata[GPIO_WIDTH-1:0] = r_moder;
            c_W_ODR:   w_rdata[GPIO_WIDTH-1:0] = r_odr;
            c_W_IDR:   w_rdata[GPIO_WIDTH-1:0] = r_idr;
            c_W_IER:   w_rdata[GPIO_WIDTH-1:0] = r_ier;
            c_W_ISR:   w_rdata[GPIO_WIDTH-1:0] = r_isr;
            default:   w_rdata = '0;
        endcase
    end

    // Response flops load only on commit, so they are nonzero for the ACK cycle alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else begin
            r_prdata  <= w_rd_ok ? w_rdata : 32'h0;
            r_pslverr <= w_commit && w_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_moder <= '0;
            r_odr   <= '0;
            r_ier   <= '0;
        end else if (w_wr_ok) begin
            if (w_word == c_W_MODER) r_moder <= w_wdata;
            if (w_word == c_W_ODR)   r_odr   <= w_wdata;
            if (w_word == c_W_IER)   r_ier   <= w_wdata;
        end
    end

    // Set has priority over a coincident write-one-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_isr <= '0;
        end else begin
            r_isr <= w_rise | (r_isr & ~w_w1c);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_idr   <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= gpio_in;
            r_idr   <= r_sync1;
            r_prev  <= r_idr;
        end
    end

    assign gpio_oe  = r_moder;
    assign gpio_out = r_odr;
    assign irq      = |(r_isr & r_ier);
endmodule
`default_nettype wire

// File: tb/tb_apb_gpio_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_gpio_slave
// Brief    : Directed self-checking bench for the APB GPIO completer.
// Revision : 1.0
// ============================================================================
module tb_apb_gpio_slave;
    logic       clk;
    logic       reset;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out;
    logic [7:0] gpio_oe;
    logic       irq;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rd;
    logic        er;
    logic        rdy1;
    logic        rdy2;

    apb_gpio_slave_if #(.ADDR_WIDTH(5)) bus ();

    apb_gpio_slave #(.GPIO_WIDTH(8), .ADDR_WIDTH(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .apb      (bus),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Setup, access (wait state), access (ACK); returns at #1 after the ACK->IDLE edge.
    task automatic apb_xfer(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                            output logic [31:0] o_rd, output logic o_er,
                            output logic o_rdy1, output logic o_rdy2);
        @(posedge clk); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = wd;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        @(negedge clk);
        o_rdy1 = bus.PREADY;
        @(posedge clk); #1;
        @(negedge clk);
        o_rdy2 = bus.PREADY; o_rd = bus.PRDATA; o_er = bus.PSLVERR;
        @(posedge clk); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (bus.PRDATA !== 32'h0) begin failures++; $display("FAIL reset_prdata got=%h want=0", bus.PRDATA); end
        checks++; if (bus.PREADY !== 1'b0) begin failures++; $display("FAIL reset_pready got=%b want=0", bus.PREADY); end
        checks++; if (bus.PSLVERR !== 1'b0) begin failures++; $display("FAIL reset_pslverr got=%b want=0", bus.PSLVERR); end
        checks++; if (gpio_oe !== 8'h00) begin failures++; $display("FAIL reset_gpio_oe got=%h want=00", gpio_oe); end
        checks++; if (gpio_out !== 8'h00) begin failures++; $display("FAIL reset_gpio_out got=%h want=00", gpio_out); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b want=0", irq); end
    endtask

    task automatic test_write_readback();
        apb_xfer(1'b1, 5'h00, 32'h0000_000F, rd, er, rdy1, rdy2);
        checks++; if (rdy1 !== 1'b0) begin failures++; $display("FAIL moder_wait got=%b want=0", rdy1); end
        checks++; if (rdy2 !== 1'b1) begin failures++; $display("FAIL moder_ready got=%b want=1", rdy2); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL moder_err got=%b want=0", er); end
        apb_xfer(1'b1, 5'h04, 32'h0000_00A5, rd, er, rdy1, rdy2);
        checks++; if (rdy1 !== 1'b0) begin failures++; $display("FAIL odr_wait got=%b want=0", rdy1); end
        checks++; if (rdy2 !== 1'b1) begin failures++; $display("FAIL odr_ready got=%b want=1", rdy2); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL odr_err got=%b want=0", er); end
        @(negedge clk);
        checks++; if (gpio_oe !== 8'h0F) begin failures++; $display("FAIL gpio_oe got=%h want=0f", gpio_oe); end
        checks++; if (gpio_out !== 8'hA5) begin failures++; $display("FAIL gpio_out got=%h want=a5", gpio_out); end
        apb_xfer(1'b0, 5'h00, 32'h0, rd, er, rdy1, rdy2);
        checks++; if (rd !== 32'h0000_000F) begin failures++; $display("FAIL rd_moder got=%h want=0000000f", rd); end
        // PRDATA/PREADY must drop back to zero once the transfer is over.
        @(negedge clk);
        checks++; if (bus.PRDATA !== 32'h0) begin failures++; $display("FAIL idle_prdata got=%h want=0", bus.PRDATA); end
        checks++; if (bus.PREADY !== 1'b0) begin failures++; $display("FAIL idle_pready got=%b want=0", bus.PREADY); end
        apb_xfer(1'b0, 5'h04, 32'h0, rd, er, rdy1, rdy2);
        checks++; if (rd !== 32'h0000_00A5) begin failures++; $display("FAIL rd_odr got=%h want=000000a5", rd); end
    endtask

    task automatic test_idr_and_errors();
        gpio_in = 8'h3C;
        repeat (3) @(posedge clk);
        #1;
        apb_xfer(1'b0, 5'h08, 32'h0, rd, er, rdy1, rdy2);
        checks++; if (rd !== 32'h0000_003C) begin failures++; $display("FAIL rd_idr got=%h want=0000003c", rd); end
        apb_xfer(1'b1, 5'h08, 32'h0000_00FF, rd, er, rdy1, rdy2);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL wr_idr_err got=%b want=1", er); end
        apb_xfer(1'b0, 5'h08, 32'h0, rd, er, rdy1, rdy2);
        checks++; if (rd !== 32'h0000_003C) begin failures++; $display("FAIL idr_unchanged got=%h want=0000003c", rd); end
        apb_xfer(1'b0, 5'h14, 32'h0, rd, er, rdy1, rdy2);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL rd_0x14_err got=%b want=1", er); end
        apb_xfer(1'b0, 5'h02, 32'h0, rd, er, rdy1, rdy2);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL rd_0x02_err got=%b want=1", er); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rd_0x02_data got=%h want=0", rd); end
        checks++; if (rdy2 !== 1'b1) begin failures++; $display("FAIL rd_0x02_ready got=%b want=1", rdy2); end
    endtask

    task automatic test_interrupt();
        // Bits 4 and 5 rose as inputs during the IDR step; bits 2,3 were outputs.
        apb_xfer(1'b0, 5'h10, 32'h0, rd, er, rdy1, rdy2);
        checks++; if (rd !== 32'h0000_0030) begin failures++; $display("FAIL isr_pre got=%h want=00000030", rd); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_no_ier got=%b want=0", irq); end
        apb_xfer(1'b1, 5'h10, 32'h0000_00FF, rd, er, rdy1, rdy2);
        apb_xfer(1'b1, 5'h0C, 32'h0000_0080, rd, er, rdy1, rdy2);
        apb_xfer(1'b0, 5'h10, 32'h0, rd, er, rdy1, rdy2);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL isr_cleared_all got=%h want=0", rd); end
        gpio_in = 8'hBD;
        repeat (3) @(posedge clk);
        #1;
        apb_xfer(1'b0, 5'h10, 32'h0, rd, er, rdy1, rdy2);
        checks++; if (rd !== 32'h0000_0080) begin failures++; $display("FAIL isr_rise got=%h want=00000080", rd); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_set got=%b want=1", irq); end
        apb_xfer(1'b1, 5'h10, 32'h0000_0080, rd, er, rdy1, rdy2);
        apb_xfer(1'b0, 5'h10, 32'h0, rd, er, rdy1, rdy2);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL isr_w1c got=%h want=0", rd); end
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b want=0", irq); end
    endtask

    task automatic test_set_clear_conflict();
        @(posedge clk); #1;
        gpio_in = 8'h3D;
        repeat (4) @(posedge clk);
        #1;
        // Pin change here lands in ISR exactly on the W1C commit edge of this write.
        gpio_in = 8'hBD;
        apb_xfer(1'b1, 5'h10, 32'h0000_0080, rd, er, rdy1, rdy2);
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL conflict_irq got=%b want=1", irq); end
        apb_xfer(1'b0, 5'h10, 32'h0, rd, er, rdy1, rdy2);
        checks++; if (rd !== 32'h0000_0080) begin failures++; $display("FAIL conflict_isr got=%h want=00000080", rd); end
    endtask

    task automatic test_reset_mid_transfer();
        @(posedge clk); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 5'h04; bus.PWDATA = 32'hFF;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (gpio_out !== 8'h00) begin failures++; $display("FAIL abort_gpio_out got=%h want=00", gpio_out); end
        checks++; if (gpio_oe !== 8'h00) begin failures++; $display("FAIL abort_gpio_oe got=%h want=00", gpio_oe); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL abort_irq got=%b want=0", irq); end
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        apb_xfer(1'b0, 5'h04, 32'h0, rd, er, rdy1, rdy2);
        checks++; if (rdy1 !== 1'b0) begin failures++; $display("FAIL post_rst_wait got=%b want=0", rdy1); end
        checks++; if (rdy2 !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%b want=1", rdy2); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL post_rst_odr got=%h want=0", rd); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL post_rst_err got=%b want=0", er); end
    endtask

    initial begin
        reset = 1'b0;
        gpio_in = 8'h00;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0; bus.PWDATA = '0;
        #2 reset = 1'b1;
        test_reset();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        test_write_readback();
        test_idr_and_errors();
        test_interrupt();
        test_set_clear_conflict();
        test_reset_mid_transfer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
